rr_arbiter_8to1: RTL and testbench



---
 rtl/rr_arbiter_8to1_pkg.sv | 13 +
 rtl/rr_arbiter_8to1_pick.sv | 28 ++
 rtl/rr_arbiter_8to1.sv | 87 ++++++++
 tb/tb_rr_arbiter_8to1.sv | 136 +++++++++++++
 4 files changed

// File: rtl/rr_arbiter_8to1_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter: requester count,
// select width and FSM state encoding.
package rr_arbiter_8to1_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8to1_pick.sv
// rr_pick_8: combinational round-robin picker. Finds the first set request at or
// above ptr, wrapping from 7 back to 0.
module rr_pick_8
    import rr_arbiter_8to1_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        // Rotate so that bit ptr lands at position 0, encode, then rotate the index back.
        dbl = {req, req} >> ptr;
        rot = dbl[N_REQ-1:0];
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        idx = off + ptr;
        any = |req;
    end

endmodule

// File: rtl/rr_arbiter_8to1.sv
// Round-robin arbiter sharing one 32-bit mux slot among 8 requesters with bounded bursts.
// Define ARB_HIGH_PRIO_EN to give requester 0 absolute, burst-unlimited priority.
module rr_arbiter_8to1
    import rr_arbiter_8to1_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic             beat,
    output logic             busy
);

    // Handshake: out_valid is high while granted and the owner still requests;
    // a beat transfers on any cycle where out_valid and out_ready are both high.
    arb_state_e       state;
    logic [SEL_W-1:0] rr_ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic [SEL_W-1:0] pick_idx;
    logic [SEL_W-1:0] winner;
    logic             pick_any;
    logic             last_beat;
    logic             hp_owner;
    logic             release_now;

    rr_pick_8 u_pick (
        .req (req),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign out_valid = (state == ARB_GRANT) & req[sel];
    assign beat      = out_valid & out_ready;
    assign busy      = (state == ARB_GRANT);
    assign last_beat = beat && (beat_cnt == CNT_W'(MAX_BURST - 1));

`ifdef ARB_HIGH_PRIO_EN
    assign winner   = req[0] ? '0 : pick_idx;
    assign hp_owner = (sel == '0);
`else
    assign winner   = pick_idx;
    assign hp_owner = 1'b0;
`endif

    // A dropped request always releases; the burst limit does not apply to the priority owner.
    assign release_now = !req[sel] || (!hp_owner && last_beat);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ARB_IDLE;
            sel      <= '0;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        sel      <= winner;
                        grant    <= N_REQ'(1) << winner;
                        beat_cnt <= '0;
                        state    <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (release_now) begin
                        state    <= ARB_IDLE;
                        grant    <= '0;
                        beat_cnt <= '0;
                        if (!hp_owner) rr_ptr <= sel + 1'b1;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8to1.sv
// Directed bench for rr_arbiter_8to1 (MAX_BURST=4): each cycle's outputs are checked
// against hand-computed grant/sel/out_valid/beat/busy values.
module tb_rr_arbiter_8to1;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out_valid;
    logic       beat;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    rr_arbiter_8to1 #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .beat      (beat),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input string fld, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    // Inputs for this cycle are already driven; check outputs mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic v, input logic b, input logic bz);
        #1;
        chk(tag, "grant", grant, g);
        chk(tag, "sel", {5'd0, sel}, {5'd0, s});
        chk(tag, "out_valid", {7'd0, out_valid}, {7'd0, v});
        chk(tag, "beat", {7'd0, beat}, {7'd0, b});
        chk(tag, "busy", {7'd0, busy}, {7'd0, bz});
        tick();
    endtask

    task automatic do_reset(input string tag, input logic [7:0] r, input logic rdy);
        reset     = 1'b1;
        req       = r;
        out_ready = rdy;
        tick();
        cyc(tag, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // n beats on requester idx followed by the mandatory IDLE bubble.
    task automatic burst(input string tag, input int idx, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 8'h01 << idx, 3'(idx), 1'b1, 1'b1, 1'b1);
        cyc(tag, 8'h00, 3'(idx), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset     = 1'b1;
        req       = 8'h00;
        out_ready = 1'b0;
        tick();

        // Reset with all requesting, then 0 gets 4 beats, a bubble, then 1.
        do_reset("t1_rst", 8'hFF, 1'b1);
        cyc("t1_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        burst("t1_b0", 0, 4);
        cyc("t1_g1", 8'h02, 3'd1, 1'b1, 1'b1, 1'b1);

        // 0 and 7 alternate, exercising the 7->0 pointer wrap.
        do_reset("t2_rst", 8'h81, 1'b1);
        cyc("t2_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        burst("t2_b0a", 0, 4);
        burst("t2_b7a", 7, 4);
        burst("t2_b0b", 0, 4);
        burst("t2_b7b", 7, 4);

        // Stall: requester 3 held 10 cycles with no beats, then a full 4-beat burst.
        do_reset("t3_rst", 8'h08, 1'b0);
        cyc("t3_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc("t3_stall", 8'h08, 3'd3, 1'b1, 1'b0, 1'b1);
        out_ready = 1'b1;
        burst("t3_b3", 3, 4);

        // Requester 5 drops after 2 beats; next search starts at 6, so 7 beats 1.
        do_reset("t4_rst", 8'h20, 1'b1);
        cyc("t4_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("t4_b5", 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
        cyc("t4_b5", 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
        req = 8'h82;
        cyc("t4_drop", 8'h20, 3'd5, 1'b0, 1'b0, 1'b1);
        cyc("t4_bub", 8'h00, 3'd5, 1'b0, 1'b0, 1'b0);
        cyc("t4_g7", 8'h80, 3'd7, 1'b1, 1'b1, 1'b1);

        // Reset mid-burst on requester 2; pointer returns to 0 so requester 0 wins next.
        do_reset("t5_rst", 8'h05, 1'b1);
        cyc("t5_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        burst("t5_b0", 0, 4);
        cyc("t5_b2", 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
        cyc("t5_b2", 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        cyc("t5_inflight", 8'h04, 3'd2, 1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        cyc("t5_after", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("t5_g0", 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);

`ifdef ARB_HIGH_PRIO_EN
        // Requester 0 keeps the grant past MAX_BURST until it drops its request.
        do_reset("t6_rst", 8'h11, 1'b1);
        cyc("t6_idle", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc("t6_hp", 8'h01, 3'd0, 1'b1, 1'b1, 1'b1);
        req = 8'h10;
        cyc("t6_drop", 8'h01, 3'd0, 1'b0, 1'b0, 1'b1);
        cyc("t6_bub", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc("t6_g4", 8'h10, 3'd4, 1'b1, 1'b1, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
